pbit_bank: RTL and testbench

//  Bank of N_PBITS p-bits: per-channel LFSR RNG plus a signed activation with inverse-temperature (beta) shift.

---
 rtl/pbit_bank.sv | 150 +++++++++++++++
 tb/tb_pbit_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_bank.sv
// pbit_bank: bank of probabilistic bits, each an LFSR compared against a beta-scaled signed bias.
// One start request runs one Gibbs sweep, either one bit per cycle or all bits in one cycle.
`default_nettype none

module pbit_bank #(
    parameter int          N_PBITS = 4,
    parameter int          BIAS_W  = 7,
    parameter int          RNG_W   = 32,
    parameter logic [31:0] SEED    = 32'd1,
    parameter int          CNT_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        start_i,
    input  logic                        mode_i,
    input  logic [2:0]                  beta_i,
    input  logic [N_PBITS*BIAS_W-1:0]   bias_i,
    input  logic [N_PBITS-1:0]          clamp_en_i,
    input  logic [N_PBITS-1:0]          clamp_val_i,
    output logic [N_PBITS-1:0]          pbit_state_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CNT_W-1:0]            sweep_count_o
);

    localparam int IDX_W = (N_PBITS > 1) ? $clog2(N_PBITS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Right-shift Galois feedback masks for maximal-length sequences.
    localparam logic [63:0] TAPS64 = (RNG_W == 8)  ? 64'h0000_0000_0000_00B8 :
                                     (RNG_W == 16) ? 64'h0000_0000_0000_B400 :
                                     (RNG_W == 24) ? 64'h0000_0000_00E1_0000 :
                                                     64'h0000_0000_8020_0003;
    localparam logic [RNG_W-1:0] TAPS = TAPS64[RNG_W-1:0];

    localparam logic signed [BIAS_W+7:0] S_HI = (BIAS_W+8)'((2 ** (BIAS_W - 1)) - 1);
    localparam logic signed [BIAS_W+7:0] S_LO = (BIAS_W+8)'(-(2 ** (BIAS_W - 1)));

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               mode_q,  mode_d;
    logic [N_PBITS-1:0] pbit_q,  pbit_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [N_PBITS-1:0] w_new;

    for (genvar i = 0; i < N_PBITS; i++) begin : g_ch
        localparam logic [RNG_W-1:0] SEED_RAW = RNG_W'(SEED + 32'(i));
        localparam logic [RNG_W-1:0] SEED_I   = (SEED_RAW == '0) ? RNG_W'(1) : SEED_RAW;

        logic [RNG_W-1:0]         lfsr_q;
        logic signed [BIAS_W-1:0] w_b;
        logic signed [BIAS_W+7:0] w_s;
        logic signed [RNG_W:0]    w_sum;
        logic                     w_act;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lfsr_q <= SEED_I;
            end else if (en_i) begin
                lfsr_q <= {1'b0, lfsr_q[RNG_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
            end
        end

        assign w_b = bias_i[i*BIAS_W +: BIAS_W];
        assign w_s = {{8{w_b[BIAS_W-1]}}, w_b} << beta_i;
        // Only reached when |s| fits in BIAS_W bits, so the narrow slice is exact.
        assign w_sum = {w_s[BIAS_W-1], w_s[BIAS_W-1:0], {(RNG_W-BIAS_W){1'b0}}}
                     + {lfsr_q[RNG_W-1], lfsr_q};

        always_comb begin
            w_act = 1'b0;
            if (w_s >= S_HI) begin
                w_act = 1'b1;
            end else if (w_s <= S_LO) begin
                w_act = 1'b0;
            end else begin
                w_act = (w_sum >= 0);
            end
        end

        assign w_new[i] = clamp_en_i[i] ? clamp_val_i[i] : w_act;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            pbit_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            pbit_q  <= pbit_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        pbit_d  = pbit_q;
        cnt_d   = cnt_q;
        if (en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_SWEEP;
                        mode_d  = mode_i;
                        idx_d   = '0;
                    end
                end
                S_SWEEP: begin
                    if (mode_q) begin
                        pbit_d  = w_new;
                        state_d = S_DONE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        pbit_d[idx_q] = w_new[idx_q];
                        if (idx_q == IDX_W'(N_PBITS - 1)) begin
                            idx_d   = '0;
                            state_d = S_DONE;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o        = (state_q == S_SWEEP);
        done_o        = (state_q == S_DONE);
        pbit_state_o  = pbit_q;
        sweep_count_o = cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_pbit_bank.sv
// Directed bench for pbit_bank: hard activations, clamping, sequencing, freeze, reset and LFSR statistics.
`default_nettype none

module tb_pbit_bank;

    localparam int N  = 4;
    localparam int BW = 7;
    localparam int RW = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b1;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic [2:0]      beta = 3'd0;
    logic [N*BW-1:0] bias = '0;
    logic [N-1:0]    clamp_en = '0;
    logic [N-1:0]    clamp_val = '0;
    logic [N-1:0]    pbit;
    logic            busy;
    logic            done;
    logic [CW-1:0]   cnt;

    int n_chk  = 0;
    int n_fail = 0;

    pbit_bank #(
        .N_PBITS(N), .BIAS_W(BW), .RNG_W(RW), .SEED(32'd1), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_i(start), .mode_i(mode),
        .beta_i(beta), .bias_i(bias), .clamp_en_i(clamp_en), .clamp_val_i(clamp_val),
        .pbit_state_o(pbit), .busy_o(busy), .done_o(done), .sweep_count_o(cnt)
    );

    always #5 clk = ~clk;

    // Reference LFSRs: x^32+x^22+x^2+x+1, right-shifting Galois form, seeds 1..N.
    logic [RW-1:0] m_lfsr [N];
    logic [RW-1:0] m_prev [N];

    function automatic logic [RW-1:0] lfsr_step(input logic [RW-1:0] v);
        logic [RW-1:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_lfsr[i] <= RW'(i + 1);
        end else if (en) begin
            m_prev <= m_lfsr;
            for (int i = 0; i < N; i++) m_lfsr[i] <= lfsr_step(m_lfsr[i]);
        end
    end

    function automatic logic [N*BW-1:0] pk(input int b3, input int b2, input int b1, input int b0);
        return {BW'(b3), BW'(b2), BW'(b1), BW'(b0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start a parallel sweep and stop at the DONE cycle.
    task automatic par_sweep();
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int exp_cnt;
    int n_mis;
    int ones [N];
    logic [N-1:0] exp_bits;

    initial begin
        exp_cnt = 0;
        n_mis   = 0;
        for (int i = 0; i < N; i++) ones[i] = 0;

        // Reset state
        tick();
        tick();
        chk("rst_pbit", 32'(pbit), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_cnt",  32'(cnt),  32'h0);
        rst_n = 1'b1;
        tick();

        // Sequential sweep, all biases saturated high
        bias  = pk(63, 63, 63, 63);
        beta  = 3'd0;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("seq_busy", 32'(busy), 32'h1);
        chk("seq_pbit0", 32'(pbit), 32'h0);
        for (int i = 1; i <= N; i++) begin
            tick();
            chk("seq_pbit", 32'(pbit), 32'((1 << i) - 1));
        end
        exp_cnt = 1;
        chk("seq_done", 32'(done), 32'h1);
        chk("seq_busy_off", 32'(busy), 32'h0);
        chk("seq_cnt", 32'(cnt), 32'(exp_cnt % 16));
        tick();
        chk("seq_done_pulse", 32'(done), 32'h0);

        // Parallel sweep with opposite hard activations
        bias  = pk(-64, 63, -64, 63);
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("par_busy", 32'(busy), 32'h1);
        tick();
        exp_cnt++;
        chk("par_pbit", 32'(pbit), 32'h5);
        chk("par_done", 32'(done), 32'h1);
        chk("par_busy_off", 32'(busy), 32'h0);
        chk("par_cnt", 32'(cnt), 32'(exp_cnt % 16));
        tick();
        chk("par_done_pulse", 32'(done), 32'h0);

        // Clamping and beta-scaled thresholds
        bias = pk(63, 63, 63, 63);
        clamp_en = 4'b0001; clamp_val = 4'b0000;
        par_sweep(); exp_cnt++;
        chk("clamp_one", 32'(pbit), 32'he);
        tick();
        clamp_en = 4'b1111; clamp_val = 4'b1010;
        par_sweep(); exp_cnt++;
        chk("clamp_all", 32'(pbit), 32'ha);
        tick();
        clamp_en = 4'b0000; bias = pk(5, 5, 5, 5); beta = 3'd4;
        par_sweep(); exp_cnt++;
        chk("beta_hard1", 32'(pbit), 32'hf);
        tick();
        bias = pk(-4, -4, -4, -4);
        par_sweep(); exp_cnt++;
        chk("beta_hard0", 32'(pbit), 32'h0);
        chk("cnt_after_par", 32'(cnt), 32'(exp_cnt % 16));
        tick();

        // Freeze mid sequential sweep; start held high during SWEEP
        beta  = 3'd0;
        bias  = pk(63, 63, -64, 63);
        mode  = 1'b0;
        start = 1'b1;
        tick();
        tick();
        tick();
        chk("frz_pre", 32'(pbit), 32'h1);
        en = 1'b0;
        repeat (5) tick();
        chk("frz_pbit", 32'(pbit), 32'h1);
        chk("frz_busy", 32'(busy), 32'h1);
        chk("frz_done", 32'(done), 32'h0);
        en = 1'b1;
        tick();
        chk("frz_resume2", 32'(pbit), 32'h5);
        tick();
        exp_cnt++;
        chk("frz_resume3", 32'(pbit), 32'hd);
        chk("frz_done_on", 32'(done), 32'h1);
        start = 1'b0;
        en = 1'b0;
        repeat (3) tick();
        chk("done_stretch", 32'(done), 32'h1);
        chk("done_stretch_cnt", 32'(cnt), 32'(exp_cnt % 16));
        en = 1'b1;
        tick();
        chk("done_release", 32'(done), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a sweep
        bias  = pk(63, 63, 63, 63);
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pbit", 32'(pbit), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_cnt",  32'(cnt),  32'h0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;

        // Unbiased parallel sweeps against the reference LFSRs; counter wrap
        bias  = '0;
        beta  = 3'd0;
        mode  = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            tick();
            tick();
            for (int i = 0; i < N; i++) exp_bits[i] = ~m_prev[i][RW-1];
            if (pbit !== exp_bits) n_mis++;
            for (int i = 0; i < N; i++) ones[i] += int'(pbit[i]);
            if (k == 14) chk("cnt_15", 32'(cnt), 32'd15);
            if (k == 15) chk("cnt_wrap", 32'(cnt), 32'd0);
            tick();
        end
        start = 1'b0;
        chk("lfsr_exact", 32'(n_mis), 32'h0);
        for (int i = 0; i < N; i++)
            chk("ones_frac", 32'((ones[i] >= 4800) && (ones[i] <= 5200)), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
